// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer slice.
//   VGA_ADDR_W / VGA_DATA_W : default frame-buffer address width (320x240)
//                             and pixel width (matches vga_rgb)
//   gnt_e                   : RAM grant owner for the current RAM cycle
package vga_pkg;

  localparam int unsigned VGA_ADDR_W = 17;
  localparam int unsigned VGA_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

endpackage

// File: rtl/vga_wfifo.sv
// Write-posting FIFO for frame-buffer writes.
//   clk, rst              : clock, synchronous active-high reset
//   push, push_addr/data  : enqueue one write (caller guarantees !full)
//   pop                   : dequeue head (caller guarantees !empty)
//   head_addr/head_data   : current head entry
//   count, full, empty    : occupancy; full/empty derive from count
module vga_wfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 17,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_addr, push_data};
  end

  assign {head_addr, head_data} = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads win every cycle they are asked
// for; writer traffic is posted into a small FIFO and drained into idle
// RAM cycles.
//   clk, rst                      : clock, synchronous active-high reset
//   rd_req, rd_addr               : display read, one pixel per cycle
//   rd_valid, rd_data             : read return, fixed 3-cycle latency
//   wr_valid/addr/data, wr_ready  : writer handshake into the FIFO
//   ram_addr/we/wdata, ram_rdata  : single-port RAM, 1-cycle registered read
//   wr_pending                    : queued-write count
//   starve, starve_clr            : sticky write-starvation flag and clear
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W      = VGA_ADDR_W,
  parameter int unsigned DATA_W      = VGA_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ready,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic                         ram_we,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic [$clog2(WFIFO_DEPTH):0] wr_pending,
  output logic                         starve,
  input  logic                         starve_clr
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  gnt_e              state;
  gnt_e              state_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;

  logic              push;
  logic              pop;
  logic              blocked;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic              rd_p1;
  logic              rd_p2;
  logic [SW-1:0]     wait_cnt;

  assign wr_ready = !rst && !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign pop      = !rd_req && !fifo_empty;
  assign blocked  = !fifo_empty && !pop;

  vga_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (wr_pending),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = GNT_NONE;
    addr_next  = '0;
    wdata_next = '0;
    if (rd_req) begin
      state_next = GNT_RD;
      addr_next  = rd_addr;
    end else if (!fifo_empty) begin
      state_next = GNT_WR;
      addr_next  = head_addr;
      wdata_next = head_data;
    end
  end

  // state names the owner of the RAM cycle that the registered outputs drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GNT_NONE;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state     <= state_next;
      ram_addr  <= addr_next;
      ram_we    <= (state_next == GNT_WR);
      ram_wdata <= wdata_next;
    end
  end

  // Request -> RAM address (N+1) -> RAM data (N+2) -> rd_data (N+3).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1    <= 1'b0;
      rd_p2    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_p1    <= rd_req;
      rd_p2    <= rd_p1;
      rd_valid <= rd_p2;
      if (rd_p2) rd_data <= ram_rdata;
    end
  end

  // The flag rises in the same cycle the counter reaches STARVE_MAX;
  // a set in that cycle overrides a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else begin
      if (!blocked)
        wait_cnt <= '0;
      else if (wait_cnt != SW'(STARVE_MAX))
        wait_cnt <= wait_cnt + 1'b1;

      if (blocked && (wait_cnt >= SW'(STARVE_MAX - 1)))
        starve <= 1'b1;
      else if (starve_clr)
        starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [2:0]  wr_pending;
  logic        starve;
  logic        starve_clr;

  logic        ld_en;
  logic [16:0] ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  mem [0:131071];

  int n_pass;
  int n_total;

  vga_fb_arbiter #(
    .ADDR_W      (17),
    .DATA_W      (8),
    .WFIFO_DEPTH (4),
    .STARVE_MAX  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .wr_pending (wr_pending),
    .starve     (starve),
    .starve_clr (starve_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model with a bench-side preload port.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rd;
    logic [16:0] ra;
    logic        wv;
    logic [16:0] wa;
    logic [7:0]  wd;
    logic        e_we;
    logic        c_addr;
    logic [16:0] e_addr;
    logic [7:0]  e_wd;
    logic [2:0]  e_pend;
    logic        e_ready;
  } vec_t;

  vec_t vecs [13];

  logic [11:0] pat_rd;
  logic [11:0] pat_wv;
  logic [11:0] pat_we;
  logic [11:0] rd_hist;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    starve_clr = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    //                rd    ra        wv    wa        wd       we    ca    e_addr    e_wd     pend   rdy
    vecs[0]  = '{1'b1, 17'h100, 1'b1, 17'h200, 8'h11, 1'b0, 1'b1, 17'h100, 8'h00, 3'd1, 1'b1};
    vecs[1]  = '{1'b0, 17'h000, 1'b1, 17'h201, 8'h22, 1'b1, 1'b1, 17'h200, 8'h11, 3'd1, 1'b1};
    vecs[2]  = '{1'b1, 17'h101, 1'b0, 17'h000, 8'h00, 1'b0, 1'b1, 17'h101, 8'h00, 3'd1, 1'b1};
    vecs[3]  = '{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b1, 1'b1, 17'h201, 8'h22, 3'd0, 1'b1};
    vecs[4]  = '{1'b0, 17'h000, 1'b1, 17'h202, 8'h33, 1'b0, 1'b0, 17'h000, 8'h00, 3'd1, 1'b1};
    vecs[5]  = '{1'b1, 17'h102, 1'b1, 17'h203, 8'h44, 1'b0, 1'b1, 17'h102, 8'h00, 3'd2, 1'b1};
    vecs[6]  = '{1'b1, 17'h103, 1'b1, 17'h204, 8'h55, 1'b0, 1'b1, 17'h103, 8'h00, 3'd3, 1'b1};
    vecs[7]  = '{1'b1, 17'h104, 1'b1, 17'h205, 8'h66, 1'b0, 1'b1, 17'h104, 8'h00, 3'd4, 1'b0};
    vecs[8]  = '{1'b0, 17'h000, 1'b1, 17'h206, 8'h77, 1'b1, 1'b1, 17'h202, 8'h33, 3'd3, 1'b1};
    vecs[9]  = '{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b1, 1'b1, 17'h203, 8'h44, 3'd2, 1'b1};
    vecs[10] = '{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b1, 1'b1, 17'h204, 8'h55, 3'd1, 1'b1};
    vecs[11] = '{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b1, 1'b1, 17'h205, 8'h66, 3'd0, 1'b1};
    vecs[12] = '{1'b0, 17'h000, 1'b0, 17'h000, 8'h00, 1'b0, 1'b0, 17'h000, 8'h00, 3'd0, 1'b1};

    // Reset state
    tick(); tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_starve", starve, 0);
    check("rst_wr_pending", wr_pending, 0);
    rst = 1'b0;
    #1;
    check("post_rst_wr_ready", wr_ready, 1);
    tick();

    // Arbitration vectors
    for (int i = 0; i < 13; i++) begin
      rd_req = vecs[i].rd; rd_addr = vecs[i].ra;
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      tick();
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].e_we);
      if (vecs[i].c_addr) check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].e_wd);
      check($sformatf("vec%0d_wr_pending", i), wr_pending, vecs[i].e_pend);
      check($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].e_ready);
    end
    rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

    // Read latency: exactly +3
    ld_en = 1'b1; ld_addr = 17'h00010; ld_data = 8'hA5;
    tick();
    ld_en = 1'b0;
    rd_req = 1'b1; rd_addr = 17'h00010;
    tick();
    check("lat_n1_valid", rd_valid, 0);
    rd_req = 1'b0;
    tick();
    check("lat_n2_valid", rd_valid, 0);
    tick();
    check("lat_n3_valid", rd_valid, 1);
    check("lat_n3_data", rd_data, 8'hA5);
    tick();
    check("lat_n4_valid", rd_valid, 0);

    // Fill under read pressure, then drain in push order
    rd_req = 1'b1; rd_addr = 17'h300;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 17'h400 + 17'(i); wr_data = 8'hE0 + 8'(i);
      tick();
    end
    check("fill_pending", wr_pending, 4);
    check("fill_ready", wr_ready, 0);
    wr_addr = 17'h404; wr_data = 8'hE5;
    tick(); tick();
    check("fill_held_pending", wr_pending, 4);
    check("fill_held_we", ram_we, 0);
    rd_req = 1'b0;
    tick();
    check("drain0_we", ram_we, 1);
    check("drain0_addr", ram_addr, 17'h400);
    check("drain0_data", ram_wdata, 8'hE0);
    check("drain0_pending", wr_pending, 3);
    tick();
    wr_valid = 1'b0;
    check("drain1_we", ram_we, 1);
    check("drain1_addr", ram_addr, 17'h401);
    check("drain1_data", ram_wdata, 8'hE1);
    check("drain1_pending", wr_pending, 3);
    tick();
    check("drain2_we", ram_we, 1);
    check("drain2_data", ram_wdata, 8'hE2);
    tick();
    check("drain3_we", ram_we, 1);
    check("drain3_data", ram_wdata, 8'hE3);
    tick();
    check("drain4_we", ram_we, 1);
    check("drain4_addr", ram_addr, 17'h404);
    check("drain4_data", ram_wdata, 8'hE5);
    check("drain4_pending", wr_pending, 0);
    tick();
    check("drain_done_we", ram_we, 0);

    // Alternating reads with two queued writes
    pat_rd = 12'h057; pat_wv = 12'h003; pat_we = 12'h028; rd_hist = '0;
    for (int i = 0; i < 12; i++) begin
      rd_req = pat_rd[i]; rd_addr = 17'h600 + 17'(i);
      wr_valid = pat_wv[i]; wr_addr = 17'h500 + 17'(i); wr_data = 8'h51 + 8'(i);
      rd_hist[i] = pat_rd[i];
      tick();
      check($sformatf("alt%0d_we", i), ram_we, pat_we[i]);
      if (pat_we[i]) begin
        check($sformatf("alt%0d_addr", i), ram_addr, (i == 3) ? 17'h500 : 17'h501);
        check($sformatf("alt%0d_data", i), ram_wdata, (i == 3) ? 8'h51 : 8'h52);
      end
      check($sformatf("alt%0d_rd_valid", i), rd_valid, (i >= 2) ? rd_hist[i-2] : 1'b0);
    end
    rd_req = 1'b0; wr_valid = 1'b0;

    // Starvation flag
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    check("stv_cleared", starve, 0);
    rd_req = 1'b1; rd_addr = 17'h800;
    wr_valid = 1'b1; wr_addr = 17'h900; wr_data = 8'h99;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("stv_after7", starve, 0);
    tick();
    check("stv_after8", starve, 1);
    tick();
    rd_req = 1'b0;
    tick();
    check("stv_pop_we", ram_we, 1);
    check("stv_pop_addr", ram_addr, 17'h900);
    check("stv_pop_sticky", starve, 1);
    tick(); tick();
    check("stv_idle_sticky", starve, 1);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    check("stv_clr", starve, 0);
    tick();
    check("stv_stays_clr", starve, 0);

    // Same-cycle push and pop at count 2
    rd_req = 1'b1; rd_addr = 17'hC00;
    wr_valid = 1'b1; wr_addr = 17'h700; wr_data = 8'hC0;
    tick();
    wr_addr = 17'h701; wr_data = 8'hC1;
    tick();
    check("pp_pending2", wr_pending, 2);
    rd_req = 1'b0; wr_addr = 17'h702; wr_data = 8'hC2;
    tick();
    wr_valid = 1'b0;
    check("pp_we", ram_we, 1);
    check("pp_addr", ram_addr, 17'h700);
    check("pp_data", ram_wdata, 8'hC0);
    check("pp_pending", wr_pending, 2);
    tick();
    check("pp_next_data", ram_wdata, 8'hC1);
    check("pp_next_pending", wr_pending, 1);
    tick();
    check("pp_last_addr", ram_addr, 17'h702);
    check("pp_last_data", ram_wdata, 8'hC2);
    check("pp_last_pending", wr_pending, 0);
    tick(); tick(); tick();

    // Reset with reads in flight and writes queued
    rd_req = 1'b1; rd_addr = 17'hA00;
    wr_valid = 1'b1; wr_addr = 17'hB00; wr_data = 8'hB0;
    tick();
    wr_addr = 17'hB01; wr_data = 8'hB1;
    tick();
    wr_valid = 1'b0;
    tick(); tick();
    check("mrst_pre_pending", wr_pending, 2);
    rst = 1'b1;
    tick();
    check("mrst_rd_valid", rd_valid, 0);
    check("mrst_pending", wr_pending, 0);
    check("mrst_ready", wr_ready, 0);
    rst = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("mrst_after%0d_valid", i), rd_valid, 0);
      check($sformatf("mrst_after%0d_we", i), ram_we, 0);
    end
    check("mrst_final_pending", wr_pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, frame-buffer address width (320x240 pixels).
REQ-002 SHALL have parameter DATA_W, default 8, pixel width matching vga_rgb.
REQ-003 SHALL have parameter WFIFO_DEPTH, default 4, write-posting buffer entries (power of two).
REQ-004 SHALL have parameter STARVE_MAX, default 1024, cycles a queued write may wait before flagging starvation.
REQ-005 SHALL have ports: clk  in  1  single clock (25 MHz pixel domain).
REQ-006 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: rd_req  in  1; rd_addr  in  ADDR_W -- display read request, one pixel per asserted cycle.
REQ-008 SHALL have ports: rd_valid  out  1; rd_data  out  DATA_W -- display read return.
REQ-009 SHALL have ports: wr_valid  in  1; wr_addr  in  ADDR_W; wr_data  in  DATA_W; wr_ready  out  1 -- writer valid/ready handshake.
REQ-010 SHALL have ports: ram_addr  out  ADDR_W; ram_we  out  1; ram_wdata  out  DATA_W; ram_rdata  in  DATA_W -- single-port RAM, 1-cycle registered read.
REQ-011 SHALL have ports: wr_pending  out  clog2(WFIFO_DEPTH)+1  queued-write count; starve  out  1  sticky flag; starve_clr  in  1  clears starve.

Function
REQ-012 SHALL grant the RAM each cycle to exactly one of: display read, buffered write, none; display read has absolute priority.
REQ-013 SHALL register ram_addr/ram_we/ram_wdata: request sampled cycle N drives RAM in cycle N+1.
REQ-014 SHALL return rd_valid=1 with rd_data at cycle N+3 for every rd_req sampled at cycle N (fixed latency 3, in order, never dropped).
REQ-015 SHALL accept a write when wr_valid&&wr_ready; wr_ready=1 iff FIFO not full; accepted write enters FIFO that cycle.
REQ-016 SHALL pop the FIFO head to RAM (ram_we=1 next cycle) only in cycles where rd_req=0 and FIFO non-empty.
REQ-017 SHALL handle simultaneous push and pop in one cycle with count unchanged; push when full is impossible (wr_ready=0).
REQ-018 SHALL wrap FIFO read/write pointers modulo WFIFO_DEPTH; full/empty from count, not pointer compare.
REQ-019 SHALL perform no read-after-write forwarding: a display read of an address still queued returns RAM contents.
REQ-020 SHALL track grant state GNT_NONE/GNT_RD/GNT_WR as a registered FSM; next = GNT_RD if rd_req, else GNT_WR if FIFO non-empty, else GNT_NONE.
REQ-021 SHALL count consecutive cycles with FIFO non-empty and no pop; counter resets on any pop or when empty; saturates at STARVE_MAX.
REQ-022 SHALL set starve when counter reaches STARVE_MAX; starve stays 1 until starve_clr; if set and clear coincide, set wins.
REQ-023 SHALL drive ram_we=0 and ram_wdata=0 in GNT_RD and GNT_NONE cycles.

Reset
REQ-024 SHALL on rst: FIFO empty, wr_pending=0, wr_ready=0 during reset then 1 first cycle after, rd_valid=0, rd_data=0, ram_we=0, ram_addr=0, ram_wdata=0, starve=0, counter=0, state GNT_NONE.
REQ-025 SHALL discard in-flight reads and queued writes when rst asserts mid-operation; no rd_valid issued for them.

Structure
REQ-026 SHALL place grant-state enumeration and default ADDR_W/DATA_W constants in shared package vga_pkg.
REQ-027 SHALL implement the write buffer as sub-module vga_wfifo (sync FIFO, count output); arbitration, FSM, latency pipe and starvation logic in top.

Verification
REQ-028 SHALL: rd_req at N, addr 0x00010, RAM holds 0xA5 -> rd_valid=1, rd_data=0xA5 at N+3 exactly.
REQ-029 SHALL: 4 writes with rd_req held 1 -> wr_pending=4, wr_ready=0; 5th write held; rd_req drops -> 4 ram_we pulses on consecutive cycles in push order.
REQ-030 SHALL: rd_req alternating 1/0 with 2 queued writes -> writes issued only on rd_req=0 cycles; every read returns at +3.
REQ-031 SHALL: STARVE_MAX=8, one queued write, rd_req held 1 for 10 cycles -> starve=1 after 8th blocked cycle; remains 1 after drain until starve_clr pulse.
REQ-032 SHALL: rst for 1 cycle with 3 reads in flight and 2 writes queued -> no rd_valid, no ram_we afterward, wr_pending=0.
REQ-033 SHALL: push and pop in the same cycle at count 2 -> wr_pending stays 2, data order preserved.
